// File: rtl/gray_counter_system_n.sv
// Prescaled N-bit up/down counter that shows its value as Gray code on leds and
// as binary on bin_out, with saturate-or-wrap mode, synchronous load and a wrap strobe.
module gray_counter_system_n #(
    parameter int N   = 4,
    parameter int DIV = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_down,
    input  logic         sat,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] leds,
    output logic [N-1:0] bin_out,
    output logic         tick,
    output logic         wrap
);

    localparam int            PW     = $clog2(DIV + 1);
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [PW-1:0] P_ZERO = PW'(0);
    localparam logic [N-1:0]  B_MAX  = {N{1'b1}};
    localparam logic [N-1:0]  B_ONE  = N'(1);
    localparam logic [N-1:0]  B_ZERO = N'(0);

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic [N-1:0]  bin_q;
    logic [N-1:0]  bin_d;
    logic [N-1:0]  leds_q;
    logic          wrap_q;
    logic          wrap_d;
    logic          tick_s;

    assign tick_s  = en & (pcnt_q == P_LAST);
    // Held low while reset is asserted, even when DIV=1 makes tick follow en.
    assign tick    = rst & tick_s;
    assign leds    = leds_q;
    assign bin_out = bin_q;
    assign wrap    = wrap_q;

    // Next-state logic: load beats tick, tick steps the counter, en advances the prescaler.
    always_comb begin
        pcnt_d = pcnt_q;
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d  = load_val;
            pcnt_d = P_ZERO;
        end else if (tick_s) begin
            pcnt_d = P_ZERO;
            if (up_down) begin
                if (bin_q != B_MAX) begin
                    bin_d = bin_q + B_ONE;
                end else if (!sat) begin
                    bin_d  = B_ZERO;
                    wrap_d = 1'b1;
                end else begin
                    bin_d = bin_q;
                end
            end else begin
                if (bin_q != B_ZERO) begin
                    bin_d = bin_q - B_ONE;
                end else if (!sat) begin
                    bin_d  = B_MAX;
                    wrap_d = 1'b1;
                end else begin
                    bin_d = bin_q;
                end
            end
        end else if (en) begin
            pcnt_d = pcnt_q + P_ONE;
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // State registers; leds is re-encoded from bin_d so it tracks bin with no added latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= P_ZERO;
            bin_q  <= B_ZERO;
            leds_q <= B_ZERO;
            wrap_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            bin_q  <= bin_d;
            leds_q <= to_gray(bin_d);
            wrap_q <= wrap_d;
        end
    end

endmodule
